// File: rtl/buffer_fifo_flagged_if.sv
// -----------------------------------------------------------------------------
// buffer_fifo_flagged_if
//
// Purpose : Bundles the request, data and status signals of buffer_fifo_flagged
//           so that the producer/consumer side and the FIFO can be connected
//           through a single port. Clock and reset are not part of the bundle.
//
// Parameters
//   DEPTH      storage entries; sets the width of count
//   WORD_SIZE  data width in bits
//
// Signals
//   flush         synchronous clear of contents and error flags
//   w_enable      write request
//   data_in       write data
//   r_enable      read request (pop)
//   data_out      read data
//   full          count == DEPTH
//   empty         count == 0
//   almost_full   count >= AF_LEVEL
//   almost_empty  count <= AE_LEVEL
//   count         current occupancy, 0..DEPTH
//   overflow      sticky: a write was rejected
//   underflow     sticky: a read was rejected
//
// Modports
//   master  the side that issues requests (producer/consumer or testbench)
//   slave   the FIFO itself
// -----------------------------------------------------------------------------
interface buffer_fifo_flagged_if #(
   parameter int unsigned DEPTH     = 64,
   parameter int unsigned WORD_SIZE = 32
);

   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic                 flush;
   logic                 w_enable;
   logic [WORD_SIZE-1:0] data_in;
   logic                 r_enable;
   logic [WORD_SIZE-1:0] data_out;
   logic                 full;
   logic                 empty;
   logic                 almost_full;
   logic                 almost_empty;
   logic [CW-1:0]        count;
   logic                 overflow;
   logic                 underflow;

   modport master (
      output flush, w_enable, data_in, r_enable,
      input  data_out, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

   modport slave (
      input  flush, w_enable, data_in, r_enable,
      output data_out, full, empty, almost_full, almost_empty,
             count, overflow, underflow
   );

endinterface

// File: rtl/buffer_fifo_flagged.sv
// -----------------------------------------------------------------------------
// buffer_fifo_flagged
//
// Purpose : Parametrised synchronous FIFO placed between the UART word
//           breaker/joiner and the 32-bit word producer/consumer. Holds up to
//           DEPTH words (all entries usable), reports occupancy, programmable
//           almost-full / almost-empty thresholds, sticky overflow/underflow
//           error flags and a synchronous flush.
//
// Configuration macro
//   FIFO_FWFT_EN  undefined : registered read, data_out updates one edge after
//                             an accepted read and holds until the next one.
//                 defined   : first-word-fall-through, data_out shows the head
//                             word whenever the FIFO is not empty, 0 otherwise.
//   Flags, count and error behaviour are identical in both modes.
//
// Parameters
//   DEPTH      storage entries, >= 2, need not be a power of two
//   WORD_SIZE  data width in bits
//   AF_LEVEL   almost_full when count >= AF_LEVEL   (1..DEPTH)
//   AE_LEVEL   almost_empty when count <= AE_LEVEL  (0..DEPTH-1)
//
// Ports
//   clock  in  rising-edge clock
//   reset  in  asynchronous, active-high reset
//   bus    slave modport of buffer_fifo_flagged_if (requests, data, status)
// -----------------------------------------------------------------------------
module buffer_fifo_flagged #(
   parameter int unsigned DEPTH     = 64,
   parameter int unsigned WORD_SIZE = 32,
   parameter int unsigned AF_LEVEL  = 56,
   parameter int unsigned AE_LEVEL  = 8
) (
   input  logic                  clock,
   input  logic                  reset,
   buffer_fifo_flagged_if.slave  bus
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   typedef logic [PW-1:0] ptr_t;
   typedef logic [CW-1:0] cnt_t;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [WORD_SIZE-1:0] mem [DEPTH];

   ptr_t w_ptr_q, w_ptr_d;
   ptr_t r_ptr_q, r_ptr_d;
   cnt_t count_q, count_d;

   logic full_q;
   logic empty_q;
   logic almost_full_q;
   logic almost_empty_q;
   logic overflow_q, overflow_d;
   logic underflow_q, underflow_d;

   // Handshake qualification
   logic rd_ok;    // read would be accepted (FIFO not empty)
   logic wr_ok;    // write would be accepted (room, or a read frees a slot)
   logic rd_acc;   // read actually performed this cycle (not overridden by flush)
   logic wr_acc;   // write actually performed this cycle

   // Pointers run 0..DEPTH-1 and wrap explicitly, so DEPTH need not be 2^n.
   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
   endfunction

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable is given a default before any branch so that no
      // path leaves it unassigned; otherwise synthesis infers a latch.
      rd_ok       = bus.r_enable & ~empty_q;
      wr_ok       = bus.w_enable & (~full_q | rd_ok);
      rd_acc      = rd_ok & ~bus.flush;
      wr_acc      = wr_ok & ~bus.flush;
      w_ptr_d     = w_ptr_q;
      r_ptr_d     = r_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;

      if (bus.flush) begin
         // Flush wins over both requests; they are dropped silently.
         w_ptr_d     = '0;
         r_ptr_d     = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (wr_acc) w_ptr_d = ptr_inc(w_ptr_q);
         if (rd_acc) r_ptr_d = ptr_inc(r_ptr_q);

         unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + cnt_t'(1);
            2'b01:   count_d = count_q - cnt_t'(1);
            default: count_d = count_q;
         endcase

         // A write while full with no accompanying pop, or any read while
         // empty (even alongside a write), is rejected and latches an error.
         if (bus.w_enable & ~wr_ok) overflow_d  = 1'b1;
         if (bus.r_enable & ~rd_ok) underflow_d = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Control registers; status flags are registered from the updated count so
   // they line up with count on the same cycle.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or posedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values, independent of statement order.
      if (reset) begin
         w_ptr_q        <= '0;
         r_ptr_q        <= '0;
         count_q        <= '0;
         full_q         <= 1'b0;
         empty_q        <= 1'b1;
         almost_full_q  <= 1'b0;
         almost_empty_q <= 1'b1;
         overflow_q     <= 1'b0;
         underflow_q    <= 1'b0;
      end else begin
         w_ptr_q        <= w_ptr_d;
         r_ptr_q        <= r_ptr_d;
         count_q        <= count_d;
         full_q         <= (count_d == cnt_t'(DEPTH));
         empty_q        <= (count_d == '0);
         almost_full_q  <= (count_d >= cnt_t'(AF_LEVEL));
         almost_empty_q <= (count_d <= cnt_t'(AE_LEVEL));
         overflow_q     <= overflow_d;
         underflow_q    <= underflow_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Storage
   // ---------------------------------------------------------------------------
   // NOTE: the array has no reset; its contents are don't-care after reset and
   // leaving it out lets the array map onto RAM instead of flops.
   always_ff @(posedge clock) begin
      if (wr_acc) mem[w_ptr_q] <= bus.data_in;
   end

   // ---------------------------------------------------------------------------
   // Read data path
   // ---------------------------------------------------------------------------
`ifdef FIFO_FWFT_EN
   // Head word falls through as soon as it is stored; 0 while empty.
   assign bus.data_out = empty_q ? '0 : mem[r_ptr_q];
`else
   logic [WORD_SIZE-1:0] data_out_q;

   // Registered read: the popped word appears after the edge and holds until
   // the next accepted read.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data_out_q <= '0;
      end else if (bus.flush) begin
         data_out_q <= '0;
      end else if (rd_acc) begin
         data_out_q <= mem[r_ptr_q];
      end
   end

   assign bus.data_out = data_out_q;
`endif

   // ---------------------------------------------------------------------------
   // Status outputs
   // ---------------------------------------------------------------------------
   assign bus.count        = count_q;
   assign bus.full         = full_q;
   assign bus.empty        = empty_q;
   assign bus.almost_full  = almost_full_q;
   assign bus.almost_empty = almost_empty_q;
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_buffer_fifo_flagged.sv
// -----------------------------------------------------------------------------
// tb_buffer_fifo_flagged
//
// Self-checking bench for buffer_fifo_flagged (DEPTH=64, WORD_SIZE=32,
// AF_LEVEL=56, AE_LEVEL=8). A table of single-cycle vectors covers the basic
// handshake, then hand-written sequences cover fill/drain, pointer wrap,
// simultaneous read/write at full and empty, flush and mid-cycle reset.
// Define FIFO_FWFT_EN for both bench and RTL to exercise fall-through mode.
// -----------------------------------------------------------------------------
module tb_buffer_fifo_flagged;

   localparam int unsigned DEPTH = 64;
   localparam int unsigned WS    = 32;
   localparam int unsigned AF    = 56;
   localparam int unsigned AE    = 8;

   logic clock = 1'b0;
   logic reset;

   always #5 clock = ~clock;

   buffer_fifo_flagged_if #(.DEPTH(DEPTH), .WORD_SIZE(WS)) bus ();

   buffer_fifo_flagged #(
      .DEPTH    (DEPTH),
      .WORD_SIZE(WS),
      .AF_LEVEL (AF),
      .AE_LEVEL (AE)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus  (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   logic [WS-1:0] model_q [$];

   typedef struct {
      logic          fl;
      logic          we;
      logic [WS-1:0] din;
      logic          re;
      int            cnt;
      logic          f, e, af, ae, o, u;
      logic [WS-1:0] dout;   // registered-mode data_out after the edge
   } vec_t;

   localparam int NV = 13;
   vec_t vecs [NV];

   function automatic vec_t mk(input logic fl, we, input logic [WS-1:0] din,
                               input logic re, input int cnt,
                               input logic f, e, af, ae, o, u,
                               input logic [WS-1:0] dout);
      vec_t v;
      v.fl = fl; v.we = we; v.din = din; v.re = re; v.cnt = cnt;
      v.f = f; v.e = e; v.af = af; v.ae = ae; v.o = o; v.u = u; v.dout = dout;
      return v;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_status(input string tag, input int cnt,
                               input logic f, e, af, ae, o, u);
      check({tag, " count"},        64'(bus.count),        64'(cnt));
      check({tag, " full"},         64'(bus.full),         64'(f));
      check({tag, " empty"},        64'(bus.empty),        64'(e));
      check({tag, " almost_full"},  64'(bus.almost_full),  64'(af));
      check({tag, " almost_empty"}, 64'(bus.almost_empty), 64'(ae));
      check({tag, " overflow"},     64'(bus.overflow),     64'(o));
      check({tag, " underflow"},    64'(bus.underflow),    64'(u));
   endtask

   // One clock with the given requests; returns 1 time unit after the edge.
   task automatic step(input logic fl, we, input logic [WS-1:0] d, input logic re);
      bus.flush    = fl;
      bus.w_enable = we;
      bus.data_in  = d;
      bus.r_enable = re;
      @(posedge clock);
      #1;
      bus.flush    = 1'b0;
      bus.w_enable = 1'b0;
      bus.r_enable = 1'b0;
   endtask

   // Expected data_out after a pop, given the word popped from the model.
   function automatic logic [WS-1:0] exp_after_pop(input logic [WS-1:0] popped);
`ifdef FIFO_FWFT_EN
      return (model_q.size() > 0) ? model_q[0] : '0;
`else
      return popped;
`endif
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [WS-1:0] popped;

      bus.flush    = 1'b0;
      bus.w_enable = 1'b0;
      bus.data_in  = '0;
      bus.r_enable = 1'b0;
      reset        = 1'b1;

      // ---------------- reset state ----------------
      repeat (2) @(posedge clock);
      #1;
      check_status("reset", 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      check("reset data_out", 64'(bus.data_out), 64'h0);
      reset = 1'b0;

      // ---------------- table-driven vectors ----------------
      //               fl    we    din          re    cnt f     e     af    ae    o     u     dout
      vecs[0]  = mk(1'b0, 1'b1, 32'hA1,      1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      vecs[1]  = mk(1'b0, 1'b1, 32'hA2,      1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      vecs[2]  = mk(1'b0, 1'b0, 32'h0,       1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hA1);
      vecs[3]  = mk(1'b0, 1'b1, 32'hA3,      1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hA2);
      vecs[4]  = mk(1'b0, 1'b0, 32'h0,       1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hA2);
      vecs[5]  = mk(1'b0, 1'b0, 32'h0,       1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hA3);
      vecs[6]  = mk(1'b0, 1'b1, 32'hA4,      1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA3);
      vecs[7]  = mk(1'b0, 1'b0, 32'h0,       1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'hA4);
      vecs[8]  = mk(1'b1, 1'b1, 32'hA5,      1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      vecs[9]  = mk(1'b0, 1'b0, 32'h0,       1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h0);
      vecs[10] = mk(1'b1, 1'b0, 32'h0,       1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      vecs[11] = mk(1'b0, 1'b1, 32'hB1,      1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
      vecs[12] = mk(1'b0, 1'b0, 32'h0,       1'b1, 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'hB1);

      for (int i = 0; i < NV; i++) begin
         step(vecs[i].fl, vecs[i].we, vecs[i].din, vecs[i].re);
         check_status($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].f, vecs[i].e,
                      vecs[i].af, vecs[i].ae, vecs[i].o, vecs[i].u);
`ifndef FIFO_FWFT_EN
         check($sformatf("vec%0d data_out", i), 64'(bus.data_out), 64'(vecs[i].dout));
`endif
      end

      // ---------------- fill to full: thresholds at 8/9 and 55/56 ----------------
      model_q.delete();
      for (int i = 1; i <= int'(DEPTH); i++) begin
         step(1'b0, 1'b1, WS'(i), 1'b0);
         model_q.push_back(WS'(i));
         check_status($sformatf("fill%0d", i), i, (i == int'(DEPTH)), 1'b0,
                      (i >= int'(AF)), (i <= int'(AE)), 1'b0, 1'b0);
      end

      // ---------------- simultaneous read and write while full ----------------
      step(1'b0, 1'b1, 32'h41, 1'b1);
      popped = model_q.pop_front();
      model_q.push_back(32'h41);
      check_status("full rw", int'(DEPTH), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      check("full rw data_out", 64'(bus.data_out), 64'(exp_after_pop(popped)));

      // ---------------- write while full -> overflow ----------------
      step(1'b0, 1'b1, 32'hDEAD, 1'b0);
      check_status("overflow", int'(DEPTH), 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);

      // ---------------- drain in order ----------------
      for (int i = 0; i < int'(DEPTH); i++) begin
         step(1'b0, 1'b0, '0, 1'b1);
         popped = model_q.pop_front();
         check($sformatf("drain%0d data_out", i), 64'(bus.data_out), 64'(exp_after_pop(popped)));
      end
      check_status("drained", 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);

      // ---------------- simultaneous read and write while empty ----------------
      step(1'b0, 1'b1, 32'h55, 1'b1);
      model_q.push_back(32'h55);
      check_status("empty rw", 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);

      step(1'b1, 1'b0, '0, 1'b0);
      model_q.delete();
      check_status("flush1", 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

      // ---------------- pointer wrap: 3 x (40 writes, 40 reads) ----------------
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b1, WS'(32'h1000 * (r + 1) + i), 1'b0);
            model_q.push_back(WS'(32'h1000 * (r + 1) + i));
         end
         check($sformatf("wrap%0d count", r), 64'(bus.count), 64'd40);
         for (int i = 0; i < 40; i++) begin
            step(1'b0, 1'b0, '0, 1'b1);
            popped = model_q.pop_front();
            check($sformatf("wrap%0d data%0d", r, i), 64'(bus.data_out), 64'(exp_after_pop(popped)));
         end
         check_status($sformatf("wrap%0d end", r), 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      end

      // ---------------- flush with count=10 and a write in the same cycle ----------------
      step(1'b0, 1'b0, '0, 1'b1);                    // empty read -> underflow
      check("pre-flush underflow", 64'(bus.underflow), 64'd1);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, WS'(32'h300 + i), 1'b0);
      check("pre-flush count", 64'(bus.count), 64'd10);
      step(1'b1, 1'b1, 32'hBAD, 1'b0);
      check_status("flush10", 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b1, 32'h77, 1'b0);
      model_q.push_back(32'h77);
      step(1'b0, 1'b0, '0, 1'b1);
      popped = model_q.pop_front();
      check("post-flush data_out", 64'(bus.data_out), 64'(exp_after_pop(popped)));
      check_status("post-flush", 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

      // ---------------- reset mid-burst ----------------
      step(1'b0, 1'b0, '0, 1'b1);                    // sets underflow
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b1, WS'(32'h61 + i), 1'b0);
         model_q.push_back(WS'(32'h61 + i));
      end
      step(1'b0, 1'b0, '0, 1'b1);
      popped = model_q.pop_front();
      check("pre-reset data_out", 64'(bus.data_out), 64'(exp_after_pop(popped)));
      check_status("pre-reset", 4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      bus.w_enable = 1'b1;
      bus.data_in  = 32'h99;
      #3 reset = 1'b1;                               // between edges
      #1;
      check_status("mid-reset", 0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      check("mid-reset data_out", 64'(bus.data_out), 64'h0);
      @(posedge clock);
      #1;
      check("held-reset count", 64'(bus.count), 64'h0);
      bus.w_enable = 1'b0;
      reset = 1'b0;
      model_q.delete();

`ifdef FIFO_FWFT_EN
      // ---------------- first-word-fall-through ----------------
      step(1'b0, 1'b1, 32'hA5A5A5A5, 1'b0);
      check("fwft head", 64'(bus.data_out), 64'hA5A5A5A5);
      step(1'b0, 1'b0, '0, 1'b0);
      check("fwft head held", 64'(bus.data_out), 64'hA5A5A5A5);
      step(1'b0, 1'b0, '0, 1'b1);
      check("fwft pop empty", 64'(bus.empty), 64'd1);
      check("fwft pop data_out", 64'(bus.data_out), 64'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
